// File: rtl/team_06_i2c_pkg.sv
// Shared types and constants for the team_06 I2C target receiver.
// The address filter is enabled by defining TEAM_06_I2C_ADDR_MATCH_EN.
package team_06_i2c_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RX       = 2'd1,
        ACK_WAIT = 2'd2,
        ACK      = 2'd3
    } i2c_tgt_state_t;

    localparam logic I2C_ACK   = 1'b0;
    localparam int   I2C_BIT_W = 8;

    // Address byte is [7:1] address, [0] read/write; only writes are claimed.
    function automatic logic addr_hit(input logic [I2C_BIT_W-1:0] byte_in,
                                      input logic [6:0]           addr);
        return (byte_in[7:1] == addr) && (byte_in[0] == 1'b0);
    endfunction

endpackage

// File: rtl/team_06_i2c_sync.sv
// Two-flop synchronizer with a previous-value flop and edge outputs.
// Resets to 1 so an idle open-drain bus produces no edges after reset.
module team_06_i2c_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [1:0] r_sync;
    logic       r_prev;

    // Synchronizer chain and history flop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_pin};
            r_prev <= r_sync[1];
        end
    end

    assign o_level = r_sync[1];
    assign o_rise  = r_sync[1] & ~r_prev;
    assign o_fall  = ~r_sync[1] & r_prev;

endmodule

// File: rtl/team_06_i2c_target.sv
// I2C target byte receiver: LSB-first shift-in, ACK/NACK drive, valid/ready holding register.
// Define TEAM_06_I2C_ADDR_MATCH_EN to treat the first byte after START as an address.
module team_06_i2c_target
    import team_06_i2c_pkg::*;
#(
    parameter logic [6:0] TARGET_ADDR = 7'h27
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 scl_i,
    input  logic                 sda_i,
    output logic                 sda_o,
    output logic                 oeb,
    output logic [I2C_BIT_W-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic                 busy
);

`ifdef TEAM_06_I2C_ADDR_MATCH_EN
    localparam logic ADDR_EN = 1'b1;
`else
    localparam logic ADDR_EN = 1'b0;
`endif

    logic w_scl_lvl, w_scl_rise, w_scl_fall;
    logic w_sda_lvl, w_sda_rise, w_sda_fall;
    logic w_start, w_stop, w_addr_byte, w_accept;

    i2c_tgt_state_t       r_state, w_state_nxt;
    logic [2:0]           r_bit_cnt, w_bit_cnt_nxt;
    logic [I2C_BIT_W-1:0] r_shift, w_shift_nxt;
    logic [I2C_BIT_W-1:0] r_rx_data, w_rx_data_nxt;
    logic                 r_rx_valid, w_rx_valid_nxt;
    logic                 r_oeb, w_oeb_nxt;
    logic                 r_overrun, w_overrun_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_accept, w_accept_nxt;
    logic                 r_addr_phase, w_addr_phase_nxt;

    team_06_i2c_sync u_scl_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_pin   (scl_i),
        .o_level (w_scl_lvl),
        .o_rise  (w_scl_rise),
        .o_fall  (w_scl_fall)
    );

    team_06_i2c_sync u_sda_sync (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_pin   (sda_i),
        .o_level (w_sda_lvl),
        .o_rise  (w_sda_rise),
        .o_fall  (w_sda_fall)
    );

    assign w_start     = w_sda_fall & w_scl_lvl;
    assign w_stop      = w_sda_rise & w_scl_lvl;
    assign w_addr_byte = ADDR_EN & r_addr_phase;
    // An address byte is judged on the address alone; data needs room in the holding register.
    assign w_accept    = w_addr_byte ? addr_hit(r_shift, TARGET_ADDR)
                                     : (~r_rx_valid | rx_ready);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt      = r_state;
        w_bit_cnt_nxt    = r_bit_cnt;
        w_shift_nxt      = r_shift;
        w_rx_data_nxt    = r_rx_data;
        w_rx_valid_nxt   = r_rx_valid;
        w_oeb_nxt        = r_oeb;
        w_overrun_nxt    = 1'b0;
        w_busy_nxt       = r_busy;
        w_accept_nxt     = r_accept;
        w_addr_phase_nxt = r_addr_phase;

        if (r_rx_valid && rx_ready) begin
            w_rx_valid_nxt = 1'b0;
        end else begin
            w_rx_valid_nxt = r_rx_valid;
        end

        if (w_stop) begin
            w_state_nxt   = IDLE;
            w_oeb_nxt     = 1'b1;
            w_busy_nxt    = 1'b0;
            w_bit_cnt_nxt = 3'd0;
        end else if (w_start) begin
            w_state_nxt      = RX;
            w_oeb_nxt        = 1'b1;
            w_busy_nxt       = 1'b1;
            w_bit_cnt_nxt    = 3'd0;
            w_addr_phase_nxt = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    w_oeb_nxt = 1'b1;
                end
                RX: begin
                    if (w_scl_rise) begin
                        w_shift_nxt[r_bit_cnt] = w_sda_lvl;
                        w_bit_cnt_nxt          = r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            w_state_nxt = ACK_WAIT;
                        end else begin
                            w_state_nxt = RX;
                        end
                    end else begin
                        w_state_nxt = RX;
                    end
                end
                ACK_WAIT: begin
                    if (w_scl_fall) begin
                        w_accept_nxt  = w_accept;
                        w_oeb_nxt     = w_accept ? I2C_ACK : 1'b1;
                        w_overrun_nxt = ~w_accept & ~w_addr_byte;
                        w_state_nxt   = ACK;
                    end else begin
                        w_state_nxt = ACK_WAIT;
                    end
                end
                ACK: begin
                    if (w_scl_fall) begin
                        w_oeb_nxt = 1'b1;
                        if (r_accept) begin
                            if (!w_addr_byte) begin
                                w_rx_data_nxt  = r_shift;
                                w_rx_valid_nxt = 1'b1;
                            end else begin
                                w_rx_data_nxt = r_rx_data;
                            end
                            w_addr_phase_nxt = 1'b0;
                            w_state_nxt      = RX;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_state_nxt = ACK;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_oeb_nxt   = 1'b1;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_rx_data    <= 8'h00;
            r_rx_valid   <= 1'b0;
            r_oeb        <= 1'b1;
            r_overrun    <= 1'b0;
            r_busy       <= 1'b0;
            r_accept     <= 1'b0;
            r_addr_phase <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_bit_cnt    <= w_bit_cnt_nxt;
            r_shift      <= w_shift_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_oeb        <= w_oeb_nxt;
            r_overrun    <= w_overrun_nxt;
            r_busy       <= w_busy_nxt;
            r_accept     <= w_accept_nxt;
            r_addr_phase <= w_addr_phase_nxt;
        end
    end

    assign sda_o    = I2C_ACK;
    assign oeb      = r_oeb;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign overrun  = r_overrun;
    assign busy     = r_busy;

endmodule

// File: tb/tb_team_06_i2c_target.sv
// Bench for team_06_i2c_target: bit-banged I2C controller on a wired-AND bus,
// directed scenarios plus randomized bytes against a holding-register model.
module tb_team_06_i2c_target;

    localparam int Q = 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_o, oeb, rx_valid, overrun, busy;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;

    int n_chk  = 0;
    int n_pass = 0;
    int ovr_cnt = 0;

    always #5 clk = ~clk;

    assign sda_line = oeb ? sda_m : (sda_m & sda_o);

    always @(posedge clk) begin
        if (overrun) ovr_cnt <= ovr_cnt + 1;
    end

    team_06_i2c_target #(.TARGET_ADDR(7'h27)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_m),
        .sda_i    (sda_line),
        .sda_o    (sda_o),
        .oeb      (oeb),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .overrun  (overrun),
        .busy     (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        if (scl_m) begin
            sda_m = 1'b0; wq(Q);
            scl_m = 1'b0; wq(Q);
        end else begin
            sda_m = 1'b1; wq(Q);
            scl_m = 1'b1; wq(Q);
            sda_m = 1'b0; wq(Q);
            scl_m = 1'b0; wq(Q);
        end
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq(Q);
        scl_m = 1'b1; wq(Q);
        sda_m = 1'b1; wq(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            sda_m = b[i]; wq(Q);
            scl_m = 1'b1; wq(2 * Q);
            scl_m = 1'b0; wq(Q);
        end
    endtask

    task automatic ack_clock(output logic ack);
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        ack = sda_line;
        rx_ready = 1'b0; wq(Q);
        scl_m = 1'b0; wq(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        ack_clock(ack);
    endtask

    task automatic pop();
        rx_ready = 1'b1; wq(1);
        rx_ready = 1'b0;
    endtask

    task automatic start_txn();
        logic a;
        i2c_start();
`ifdef TEAM_06_I2C_ADDR_MATCH_EN
        send_byte(8'h4E, a);
        check("addr_ack", a, 1'b0);
`else
        a = 1'b0;
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic       ack, exp_valid, active;
        logic [7:0] exp_data, b;
        int         exp_ovr, ovr0, k;

        // Reset values
        wq(3);
        rst = 1'b0;
        wq(2);
        check("rst_oeb", oeb, 1'b1);
        check("rst_sda_o", sda_o, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_overrun", ovr_cnt, 0);
        check("rst_busy", busy, 1'b0);

        // Single byte, ready high
        start_txn();
        check("t1_busy", busy, 1'b1);
        rx_ready = 1'b1;
        send_byte(8'hA5, ack);
        check("t1_ack", ack, 1'b0);
        check("t1_valid", rx_valid, 1'b1);
        check("t1_data", rx_data, 8'hA5);
        i2c_stop(); wq(Q);
        check("t1_busy_stop", busy, 1'b0);
        check("t1_oeb_stop", oeb, 1'b1);

        // Held byte then overrun
        pop();
        check("t2_popped", rx_valid, 1'b0);
        start_txn();
        send_byte(8'h12, ack);
        check("t2_ack1", ack, 1'b0);
        check("t2_valid1", rx_valid, 1'b1);
        ovr0 = ovr_cnt;
        send_byte(8'h34, ack);
        check("t2_nack2", ack, 1'b1);
        check("t2_overrun", ovr_cnt - ovr0, 1);
        check("t2_data_held", rx_data, 8'h12);
        send_byte(8'h55, ack);
        check("t2_idle_ignores", ack, 1'b1);
        check("t2_idle_no_ovr", ovr_cnt - ovr0, 1);
        check("t2_idle_data", rx_data, 8'h12);
        i2c_stop(); wq(Q);
        check("t2_busy_stop", busy, 1'b0);

        // STOP mid-byte
        pop();
        ovr0 = ovr_cnt;
        start_txn();
        send_bits(8'hFF, 5);
        i2c_stop(); wq(Q);
        check("t3_valid", rx_valid, 1'b0);
        check("t3_oeb", oeb, 1'b1);
        check("t3_busy", busy, 1'b0);
        check("t3_no_ovr", ovr_cnt - ovr0, 0);
        start_txn();
        send_byte(8'h0F, ack);
        check("t3_ack", ack, 1'b0);
        check("t3_data", rx_data, 8'h0F);

        // Repeated START after 3 bits
        pop();
        send_bits(8'hFF, 3);
        start_txn();
        send_byte(8'hC3, ack);
        check("t4_ack", ack, 1'b0);
        check("t4_data", rx_data, 8'hC3);
        check("t4_valid", rx_valid, 1'b1);

        // Reset while driving ACK
        pop();
        send_bits(8'h6B, 8);
        sda_m = 1'b1; wq(Q);
        scl_m = 1'b1; wq(Q);
        check("t5_oeb_low", oeb, 1'b0);
        rst = 1'b1; wq(1);
        check("t5_oeb", oeb, 1'b1);
        check("t5_valid", rx_valid, 1'b0);
        check("t5_data", rx_data, 8'h00);
        check("t5_busy", busy, 1'b0);
        check("t5_overrun", overrun, 1'b0);
        rst = 1'b0; wq(Q);

        // Randomized traffic against the holding-register model
        exp_valid = 1'b0;
        exp_data  = 8'h00;
        exp_ovr   = ovr_cnt;
        active    = 1'b0;
        for (int it = 0; it < 30; it++) begin
            if (!active) begin
                start_txn();
                active = 1'b1;
            end
            if (exp_valid && ($urandom_range(0, 1) == 1)) begin
                pop();
                exp_valid = 1'b0;
                check("rnd_pop", rx_valid, 1'b0);
            end
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(1, 7);
                send_bits(b, k);
                i2c_stop(); wq(Q);
                active = 1'b0;
                check("rnd_part_valid", rx_valid, exp_valid);
                check("rnd_part_busy", busy, 1'b0);
            end else begin
                send_byte(b, ack);
                check("rnd_ack", ack, exp_valid);
                if (!exp_valid) begin
                    exp_valid = 1'b1;
                    exp_data  = b;
                end else begin
                    exp_ovr++;
                    active = 1'b0;
                end
                check("rnd_valid", rx_valid, exp_valid);
                check("rnd_data", rx_data, exp_data);
                check("rnd_ovr", ovr_cnt, exp_ovr);
            end
        end
        if (!scl_m) begin
            i2c_stop(); wq(Q);
        end

`ifdef TEAM_06_I2C_ADDR_MATCH_EN
        // Address match and mismatch
        pop();
        i2c_start();
        send_byte(8'h4E, ack);
        check("m_addr_ack", ack, 1'b0);
        check("m_addr_not_loaded", rx_valid, 1'b0);
        send_byte(8'h99, ack);
        check("m_data_ack", ack, 1'b0);
        check("m_data", rx_data, 8'h99);
        i2c_stop(); wq(Q);
        pop();
        ovr0 = ovr_cnt;
        i2c_start();
        send_byte(8'h50, ack);
        check("m_bad_addr_nack", ack, 1'b1);
        check("m_bad_addr_valid", rx_valid, 1'b0);
        check("m_bad_addr_no_ovr", ovr_cnt - ovr0, 0);
        i2c_stop(); wq(Q);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/team_06_i2c_target.md
# team_06_i2c_target

I2C target-side byte receiver: the far end of the team_06 I2C transmitter link. It samples the open-drain SCL/SDA bus on the system clock and detects START/STOP. It shifts in bytes LSB-first, matching the team_06 transmitter bit order, and drives the ACK/NACK bit. Each accepted byte is handed to downstream logic through a valid/ready holding register.

## Interface
- `TARGET_ADDR`, default 7'h27: 7-bit address compared only when `TEAM_06_I2C_ADDR_MATCH_EN` is defined.
- `clk` in 1: system clock; must be ≥ 8× the SCL frequency.
- `rst` in 1: reset, synchronous, active-high.
- `scl_i` in 1: raw SCL pin (asynchronous).
- `sda_i` in 1: raw SDA pin (asynchronous).
- `sda_o` out 1: SDA drive value; always 0, and only meaningful when `oeb`=0.
- `oeb` out 1: output enable, active-low. 1 = released/input, 0 = pulling SDA low.
- `rx_data` out 8: holding-register byte.
- `rx_valid` out 1: holding register full; stays high until it is consumed.
- `rx_ready` in 1: consumer accepts `rx_data` on a cycle where `rx_valid & rx_ready`.
- `overrun` out 1: one-cycle pulse when a byte is NACKed because the holding register is full.
- `busy` out 1: high from START until STOP.

## Operation
- **Reset values:** `sda_o`=0, `oeb`=1, `rx_data`=0, `rx_valid`=0, `overrun`=0, `busy`=0, state IDLE. Synchronizer flops reset to 1 (idle bus).
- **Input conditioning:**
  - SCL and SDA each pass a 2-flop synchronizer plus a previous-value flop.
  - `scl_rise`/`scl_fall` are edges of the synced SCL.
  - START = synced SDA falls while synced SCL is 1.
  - STOP = synced SDA rises while synced SCL is 1.
- **States:**
  - IDLE: `oeb`=1. START → RX with `bit_cnt`=0 and `busy`=1.
  - RX: on each `scl_rise`, `shift[bit_cnt] <= sda`, then `bit_cnt++`. On the 8th `scl_rise` (`bit_cnt` 7→0), go to ACK_WAIT.
  - ACK_WAIT: on `scl_fall`, evaluate `accept = (!rx_valid | rx_ready)` (address match is folded in only under the macro).
    - If accept: `oeb`=0.
    - If not accept: `oeb` stays 1, and `overrun` pulses when the cause is a full holding register.
    - Next state is ACK in both cases.
  - ACK: hold the drive through the 9th SCL high.
    - On the next `scl_fall`: `oeb`=1.
    - If accepted: `rx_data <= shift`, `rx_valid <= 1`, go to RX.
    - Else go to IDLE, ignoring the bus until the next START.
- **Holding register:** `rx_valid` clears on `rx_valid & rx_ready` unless a new byte loads in the same cycle. Load wins, and `rx_valid` stays 1.
- **Boundaries:**
  - A START in any state (repeated START) → RX with `bit_cnt`=0 and `oeb`=1. The partial byte is discarded.
  - A STOP in any state → IDLE, `oeb`=1, `busy`=0. A partial byte is discarded with no `rx_valid` and no `overrun`.
  - START and STOP never coincide, since they are exclusive edges of the same signal.
  - `rst` mid-byte or mid-ACK forces reset values on the next edge and releases SDA immediately.
- **Arithmetic:** `bit_cnt` is 3 bits and wraps 7→0. It needs no overflow handling.

## Timing
- Pin-to-detect latency is 3 `clk` cycles (2 sync flops + edge compare).
- `oeb` falls 1 cycle after the detected `scl_fall`, so about 4 `clk` after the SCL pin falls. It rises 1 cycle after the detected `scl_fall` that ends the ACK clock.
- `rx_valid` rises 1 cycle after the `scl_fall` that ends the ACK clock.
- `overrun` pulses in the cycle after the ACK_WAIT decision.
- `accept` samples `rx_ready` in the same cycle as the ACK_WAIT `scl_fall` decision.

## Configuration
- `TEAM_06_I2C_ADDR_MATCH_EN` defined:
  - The first byte after each START is an address byte: `addr = shift[7:1]`, `rw = shift[0]`.
  - The address byte is ACKed only if `addr == TARGET_ADDR` and `rw == 0`, and it is never loaded into `rx_data`.
  - A mismatch NACKs, goes to IDLE and does not pulse `overrun`.
  - After a matching address byte, all following bytes are data.
- Macro undefined: every byte after START is data, with no address phase. This matches the team_06 transmitter, which sends raw bytes.

## Structure
- **Package `team_06_i2c_pkg`:**
  - State enum `i2c_tgt_state_t` {IDLE, RX, ACK_WAIT, ACK}.
  - Constants `I2C_ACK` = 1'b0, `I2C_BIT_W` = 8.
- **Sub-module `team_06_i2c_sync`:** 2-flop synchronizer plus previous-value flop, with rise/fall outputs. It is instantiated once for SCL and once for SDA.

## Test plan
- START, byte 8'hA5 LSB-first, `rx_ready`=1 → SDA pulled low during the 9th clock, then `rx_valid`=1 with `rx_data`=8'hA5. Then STOP → `busy`=0, `oeb`=1.
- Two bytes 8'h12 then 8'h34 with `rx_ready`=0 → first byte ACKed and held. Second byte NACKed with `overrun` pulsing once; `rx_data` stays 8'h12; state returns to IDLE.
- STOP after 5 bits of 8'hFF → no `rx_valid`, `oeb`=1, IDLE. Then START plus byte 8'h0F → `rx_data`=8'h0F.
- Repeated START after 3 bits, then byte 8'hC3 → `rx_data`=8'hC3, with `bit_cnt` restarted.
- `rst` asserted while `oeb`=0 in ACK → next cycle `oeb`=1 and all outputs at reset values.
- Macro on, `TARGET_ADDR`=7'h27:
  - Address byte 8'h4E then 8'h99 → both ACKed, `rx_data`=8'h99.
  - Address byte 8'h50 → NACK, no `rx_valid`.
